// File: rtl/pc_pkg.sv
// Shared types and constants for the IF-stage program-counter generator.
package pc_pkg;

  typedef enum logic {
    RUN  = 1'b0,
    PEND = 1'b1
  } pc_state_e;

  localparam logic [31:0] DEF_RESET_PC = 32'h0000_3000;
  localparam logic [31:0] DEF_EXC_VEC  = 32'h0000_4180;
  localparam int unsigned PC_STEP      = 4;

endpackage

// File: rtl/pc_redirect_buf.sv
// Holds a branch redirect that resolved while fetch was stalled.
module pc_redirect_buf #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             clear,
  input  logic [WIDTH-1:0] target,
  output logic             valid,
  output logic [WIDTH-1:0] pend_target
);

  // Clear wins over load so a higher-priority redirect always drops the buffer.
  always_ff @(posedge clk) begin
    if (!reset) begin
      valid       <= 1'b0;
      pend_target <= '0;
    end else if (clear) begin
      valid       <= 1'b0;
    end else if (load) begin
      valid       <= 1'b1;
      pend_target <= target;
    end
  end

endmodule

// File: rtl/pc_gen.sv
// Program-counter generator with prioritised redirects and a stall-safe branch buffer.
// Optional alignment flag output enabled by defining PC_GEN_ALIGN_CHECK_EN.
module pc_gen
  import pc_pkg::*;
#(
  parameter int unsigned WIDTH    = 32,
  parameter logic [31:0] RESET_PC = DEF_RESET_PC,
  parameter logic [31:0] EXC_VEC  = DEF_EXC_VEC
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             br_taken,
  input  logic [WIDTH-1:0] br_target,
  input  logic             exc_req,
  input  logic             eret,
  input  logic [WIDTH-1:0] epc,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_plus_4,
  output logic [WIDTH-1:0] pc_plus_8,
  output logic             redirected,
`ifdef PC_GEN_ALIGN_CHECK_EN
  output logic             misaligned,
`endif
  output logic             pend_valid
);

  localparam logic [WIDTH-1:0] RST_PC  = WIDTH'(RESET_PC);
  localparam logic [WIDTH-1:0] EXC_PC  = WIDTH'(EXC_VEC);
  localparam logic [WIDTH-1:0] STEP_1  = WIDTH'(PC_STEP);
  localparam logic [WIDTH-1:0] STEP_2  = WIDTH'(2 * PC_STEP);

  pc_state_e        state;
  logic             buf_load;
  logic             buf_clear;
  logic [WIDTH-1:0] pend_target;
  logic             pc_load;
  logic [WIDTH-1:0] pc_next;
  logic             redirect_next;

  assign pc_plus_4 = pc + STEP_1;
  assign pc_plus_8 = pc + STEP_2;

  // Priority mux: exception > eret > live branch > buffered branch > sequential.
  always_comb begin
    pc_load       = 1'b0;
    pc_next       = pc;
    redirect_next = 1'b0;
    buf_load      = 1'b0;
    buf_clear     = 1'b0;
    if (exc_req) begin
      pc_load       = 1'b1;
      pc_next       = EXC_PC;
      redirect_next = 1'b1;
      buf_clear     = 1'b1;
    end else if (eret) begin
      pc_load       = 1'b1;
      pc_next       = epc;
      redirect_next = 1'b1;
      buf_clear     = 1'b1;
    end else if (en) begin
      pc_load = 1'b1;
      if (br_taken) begin
        pc_next       = br_target;
        redirect_next = 1'b1;
        buf_clear     = 1'b1;
      end else if (state == PEND) begin
        pc_next       = pend_target;
        redirect_next = 1'b1;
        buf_clear     = 1'b1;
      end else begin
        pc_next = pc_plus_4;
      end
    end else if (br_taken) begin
      buf_load = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc         <= RST_PC;
      state      <= RUN;
      redirected <= 1'b0;
    end else begin
      redirected <= redirect_next;
      if (pc_load) begin
        pc <= pc_next;
      end
      if (buf_clear) begin
        state <= RUN;
      end else if (buf_load) begin
        state <= PEND;
      end
    end
  end

`ifdef PC_GEN_ALIGN_CHECK_EN
  // Tracks the low bits of whatever value was last written into pc.
  always_ff @(posedge clk) begin
    if (!reset) begin
      misaligned <= 1'b0;
    end else if (pc_load) begin
      misaligned <= |pc_next[1:0];
    end
  end
`endif

  pc_redirect_buf #(
    .WIDTH(WIDTH)
  ) u_redirect_buf (
    .clk        (clk),
    .reset      (reset),
    .load       (buf_load),
    .clear      (buf_clear),
    .target     (br_target),
    .valid      (pend_valid),
    .pend_target(pend_target)
  );

endmodule

// File: tb/tb_pc_gen.sv
// Directed self-checking bench for pc_gen.
`timescale 1ns/1ps
module tb_pc_gen;

  localparam int unsigned WIDTH = 32;

  logic             clk = 1'b0;
  logic             reset;
  logic             en;
  logic             br_taken;
  logic [WIDTH-1:0] br_target;
  logic             exc_req;
  logic             eret;
  logic [WIDTH-1:0] epc;
  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] pc_plus_4;
  logic [WIDTH-1:0] pc_plus_8;
  logic             redirected;
  logic             pend_valid;
`ifdef PC_GEN_ALIGN_CHECK_EN
  logic             misaligned;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pc_gen dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .br_taken  (br_taken),
    .br_target (br_target),
    .exc_req   (exc_req),
    .eret      (eret),
    .epc       (epc),
    .pc        (pc),
    .pc_plus_4 (pc_plus_4),
    .pc_plus_8 (pc_plus_8),
    .redirected(redirected),
`ifdef PC_GEN_ALIGN_CHECK_EN
    .misaligned(misaligned),
`endif
    .pend_valid(pend_valid)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0; en = 1'b0; br_taken = 1'b0; br_target = '0;
    exc_req = 1'b0; eret = 1'b0; epc = '0;

    // Reset
    step(); step();
    check("rst_pc", pc, 32'h3000);
    check("rst_redir", 32'(redirected), 32'h0);
    check("rst_pend", 32'(pend_valid), 32'h0);
    check("rst_p4", pc_plus_4, 32'h3004);

    reset = 1'b1; en = 1'b1;
    step(); check("seq_1", pc, 32'h3004);
    step(); check("seq_2", pc, 32'h3008);
    check("seq_p4", pc_plus_4, 32'h300C);
    check("seq_p8", pc_plus_8, 32'h3010);
    step(); step(); check("seq_4", pc, 32'h3010);

    // Stall
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_pc", pc, 32'h3010);
      check("stall_redir", 32'(redirected), 32'h0);
    end
    en = 1'b1;
    step(); check("unstall_pc", pc, 32'h3014);

    // Buffered branch during a stall
    en = 1'b0; br_taken = 1'b1; br_target = 32'h3400;
    step();
    check("buf_pc", pc, 32'h3014);
    check("buf_pend", 32'(pend_valid), 32'h1);
    check("buf_redir", 32'(redirected), 32'h0);
    br_taken = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      check("buf_hold_pc", pc, 32'h3014);
      check("buf_hold_pend", 32'(pend_valid), 32'h1);
    end
    en = 1'b1;
    step();
    check("buf_rel_pc", pc, 32'h3400);
    check("buf_rel_redir", 32'(redirected), 32'h1);
    check("buf_rel_pend", 32'(pend_valid), 32'h0);
    step();
    check("buf_after_pc", pc, 32'h3404);
    check("buf_after_redir", 32'(redirected), 32'h0);

    // Last buffered request wins
    en = 1'b0; br_taken = 1'b1; br_target = 32'h3500;
    step();
    br_target = 32'h3600;
    step();
    br_taken = 1'b0; en = 1'b1;
    step(); check("last_wins_pc", pc, 32'h3600);

    // Live branch with en=1
    br_taken = 1'b1; br_target = 32'h3100;
    step();
    check("live_br_pc", pc, 32'h3100);
    check("live_br_redir", 32'(redirected), 32'h1);

    // Priority: exception over eret over branch, regardless of en
    en = 1'b0; exc_req = 1'b1; eret = 1'b1; br_taken = 1'b1;
    br_target = 32'h3500; epc = 32'h3024;
    step();
    check("exc_pc", pc, 32'h4180);
    check("exc_pend", 32'(pend_valid), 32'h0);
    check("exc_redir", 32'(redirected), 32'h1);
    exc_req = 1'b0; br_taken = 1'b0;
    step();
    check("eret_pc", pc, 32'h3024);
    check("eret_redir", 32'(redirected), 32'h1);
    eret = 1'b0;
    step();
    check("post_eret_pc", pc, 32'h3024);
    check("post_eret_redir", 32'(redirected), 32'h0);

    // Wrap at the top of the address space
    en = 1'b1; br_taken = 1'b1; br_target = 32'hFFFF_FFFC;
    step();
    check("top_pc", pc, 32'hFFFF_FFFC);
    check("top_p4", pc_plus_4, 32'h0000_0000);
    check("top_p8", pc_plus_8, 32'h0000_0004);
    br_taken = 1'b0;
    step(); check("wrap_pc", pc, 32'h0000_0000);

    // Reset while a branch is pending
    en = 1'b0; br_taken = 1'b1; br_target = 32'h3700;
    step(); check("mid_pend", 32'(pend_valid), 32'h1);
    reset = 1'b0;
    step();
    check("mid_rst_pc", pc, 32'h3000);
    check("mid_rst_pend", 32'(pend_valid), 32'h0);
    check("mid_rst_redir", 32'(redirected), 32'h0);
    reset = 1'b1; br_taken = 1'b0; en = 1'b1;
    step(); check("mid_rst_resume", pc, 32'h3004);

`ifdef PC_GEN_ALIGN_CHECK_EN
    check("align_init", 32'(misaligned), 32'h0);
    br_taken = 1'b1; br_target = 32'h3402;
    step();
    check("align_bad_pc", pc, 32'h3402);
    check("align_bad", 32'(misaligned), 32'h1);
    br_target = 32'h3404;
    step();
    check("align_ok", 32'(misaligned), 32'h0);
    br_taken = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pc_gen.md
Name: pc_gen

Overview:
Parametrised program-counter generator for the pipelined MIPS core. It is the successor to the fixed 32-bit PC register and sits at the head of the IF stage. It adds configurable width and vectors, prioritised redirect sources (exception, eret, branch/jump), and a pending-redirect buffer so a branch resolved during a stall is not lost. It also provides sequential +4/+8 outputs for the link and delay-slot paths.

Parameters:
WIDTH, 32, PC and address width in bits.
RESET_PC, 32'h0000_3000, PC value loaded on reset; truncated to WIDTH.
EXC_VEC, 32'h0000_4180, exception handler entry; truncated to WIDTH.

Ports:
clk  input  1  system clock; all state updates on posedge.
reset  input  1  synchronous, active-low reset; sampled on posedge clk; 0 = reset.
en  input  1  PC advance enable; 0 = pipeline stall.
br_taken  input  1  branch/jump redirect request from ID.
br_target  input  WIDTH  redirect target for br_taken.
exc_req  input  1  exception redirect to EXC_VEC.
eret  input  1  return-from-exception request.
epc  input  WIDTH  return address used with eret.
pc  output  WIDTH  current fetch address.
pc_plus_4  output  WIDTH  pc + 4, modulo 2^WIDTH.
pc_plus_8  output  WIDTH  pc + 8, modulo 2^WIDTH.
redirected  output  1  high for the cycle after pc was loaded from a non-sequential source.
pend_valid  output  1  a buffered branch redirect is waiting for en.

Behaviour:
- Reset (reset==0 at posedge): pc=RESET_PC, state=RUN, pend_valid=0, pend_target=0, redirected=0. Reset overrides every other input.
- pc_plus_4 and pc_plus_8 are combinational from pc. They are unsigned adds truncated to WIDTH, so 0xFFFF_FFFC+4 = 0x0000_0000.
- FSM has two states: RUN and PEND.
- Next-PC priority, evaluated each posedge when reset==1:
  1. exc_req: pc<=EXC_VEC regardless of en; clear pending; state<=RUN; redirected<=1.
  2. eret (and no exc_req): pc<=epc regardless of en; clear pending; state<=RUN; redirected<=1.
  3. en==1 and br_taken: pc<=br_target; clear pending; state<=RUN; redirected<=1.
  4. en==1, no br_taken, state==PEND: pc<=pend_target; state<=RUN; pend_valid<=0; redirected<=1.
  5. en==1, otherwise: pc<=pc_plus_4; redirected<=0.
  6. en==0 and br_taken: pc holds; pend_target<=br_target (the last request wins); state<=PEND; pend_valid<=1; redirected<=0.
  7. en==0, otherwise: pc holds; state and pend_target hold; redirected<=0.
- The branch delay slot is not handled here. The fetch of the slot is the normal sequential step that precedes the branch's redirect, so no extra bubble is inserted.
- Redirect latency: the new pc is visible one cycle after the request edge.
- pend_valid is 1 exactly when state==PEND.

Optional Feature:
Macro PC_GEN_ALIGN_CHECK_EN.
- Defined: adds output misaligned (1 bit), registered. It is set on the edge where pc is loaded with a value whose bits [1:0]!=0, and it clears on the next load of an aligned value or on reset.
- Not defined: the port is absent, and no alignment logic exists; unaligned targets are loaded unchanged.

Decomposition:
- Shared package pc_pkg holds:
  - state typedef (RUN, PEND);
  - constants for the default RESET_PC and EXC_VEC;
  - the localparam PC_STEP=4.
- One sub-module, pc_redirect_buf, is natural: it holds pend_valid/pend_target with load, clear and hold controls. pc_gen holds the FSM, priority mux and PC register.

Test Plan:
1. Reset: reset=0 for 2 cycles, then 1 with en=1 -> pc=0x3000, then 0x3004, 0x3008; pc_plus_8=0x3010 when pc=0x3008.
2. Stall: en=0 for 3 cycles at pc=0x3010 -> pc stays 0x3010, redirected=0; en=1 -> 0x3014.
3. Buffered branch: en=0, br_taken=1, br_target=0x3400 for 1 cycle, then br_taken=0 for 2 stalled cycles -> pend_valid=1 and pc holds; then en=1 -> pc=0x3400, redirected=1 for one cycle, pend_valid=0.
4. Priority: exc_req=1, eret=1, br_taken=1 (target 0x3500), en=0 in the same cycle -> pc=0x4180 and pending cleared; next cycle eret=1, epc=0x3024 -> pc=0x3024.
5. Wrap and reset mid-pend: pc=0xFFFF_FFFC with en=1 -> pc=0x0000_0000. Then buffer a branch and assert reset=0 -> pc=0x3000 and pend_valid=0.
6. Align check (PC_GEN_ALIGN_CHECK_EN): br_target=0x3402 -> misaligned=1; next br_target=0x3404 -> misaligned=0.
